armleocpu_mul32: RTL and testbench
==================================

Name: armleocpu_mul32

Overview:
- Single-cycle-latency unsigned integer multiplier for the execute stage (MUL/MULHU path).
- Accepts two XLEN-bit factors qualified by valid.
- Returns the full 2*XLEN-bit product, registered, with ready asserted exactly one clock later.
- Fully pipelined: a new operation may be issued every cycle.

Parameters:
- XLEN, 32, factor width; result is 2*XLEN bits; must be a multiple of 16.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid  in  1  request qualifier; factors are sampled on the rising edge where valid=1.
- factor0  in  XLEN  first factor (unsigned by default).
- factor1  in  XLEN  second factor (unsigned by default).
- ready  out  1  high for one cycle per accepted request; result is valid while ready=1.
- result  out  2*XLEN  registered product.

Behaviour:
- Reset (asynchronous, active-high, rst=1):
  - ready=0 and result=0 immediately, independent of clk.
  - Any operation in flight is discarded.
- Accept: on a rising edge with valid=1 and rst=0:
  - result <= factor0*factor1, full 2*XLEN width, no truncation.
  - ready <= 1.
- Idle: on a rising edge with valid=0:
  - ready <= 0.
  - result holds its previous value.
- Latency and throughput:
  - Latency is exactly 1 cycle.
  - Back-to-back valid cycles produce back-to-back ready cycles, each carrying the product of the factors sampled on the corresponding edge.
- No backpressure: ready is an output strobe, not a handshake. The consumer must take the result in the ready cycle.
- Factors are only sampled at the accepting edge; they may change freely in any other cycle.
- Arithmetic:
  - Product is computed as four 16x16 partial-product blocks per 32-bit slice, summed with correct shifts (generalised for XLEN).
  - Boundary values: 0*x=0; max*max = 2^(2*XLEN) - 2^(XLEN+1) + 1.
- Reset deasserting mid-cycle: the first accept can occur on the first rising edge after deassertion.
- No internal FSM beyond the ready flop. No combinational path from inputs to outputs.

Optional Feature:
- Macro: ARMLEOCPU_MULTIPLIER_SIGNED_EN.
- When defined:
  - Adds inputs factor0_signed (1) and factor1_signed (1), sampled together with the factors.
  - Each factor is treated as two's-complement when its flag is 1, covering MULH and MULHSU.
  - result is the 2*XLEN two's-complement product.
  - Implementation: sign-extend each factor to XLEN+1 bits, multiply, and take the low 2*XLEN bits.
- When undefined: the ports do not exist and the behaviour is purely unsigned, as above.

Decomposition:
- Shared package armleocpu_mul_pkg holds:
  - localparams MUL_XLEN=32 and MUL_RES_W=64;
  - partial-product width constant PP_W=16.
- One sub-module, armleocpu_mul16: a combinational 16x16 -> 32 unsigned multiplier.
  - Instantiated (XLEN/16)^2 times.
  - Outputs are summed in the top module before the result register.

Test Plan:
- Reset: rst=1 with valid=1 -> ready=0, result=0; after release, ready stays 0 until the first accept.
- Basic: valid=1, factor0=64, factor1=53 -> next cycle ready=1, result=3392.
- Max operands: factor0=factor1=0xFFFF_FFFF -> next cycle ready=1, result=0xFFFF_FFFE_0000_0001.
- Back-to-back: valid held high with (64,53) then (0xFFFF_FFFF,0xFFFF_FFFF) on consecutive cycles -> ready high both cycles; results 3392 then 0xFFFF_FFFE_0000_0001.
- Idle hold: valid=0 after an op -> ready=0, result unchanged; async rst mid-stream -> ready=0, result=0 immediately.
- Signed (with ARMLEOCPU_MULTIPLIER_SIGNED_EN): factor0=0xFFFF_FFFF signed, factor1=2 unsigned -> result=0xFFFF_FFFF_FFFF_FFFE.

Source files
------------

// File: rtl/armleocpu_mul_pkg.sv
// Shared constants for the armleocpu multiplier slice.
// The default datapath width and the partial-product block width live here
// so the top and the 16x16 leaf agree on them.
package armleocpu_mul_pkg;

    // Default factor width and matching full-product width.
    localparam int MUL_XLEN  = 32;
    localparam int MUL_RES_W = 2 * MUL_XLEN;

    // Width of one partial-product block factor (16x16 -> 32).
    localparam int PP_W = 16;

endpackage : armleocpu_mul_pkg

// File: rtl/armleocpu_mul16.sv
// Combinational 16x16 -> 32 unsigned multiplier leaf.
// The top instantiates a square grid of these and sums the shifted outputs.
module armleocpu_mul16
    import armleocpu_mul_pkg::*;
(
    input  logic [PP_W-1:0]   a,
    input  logic [PP_W-1:0]   b,
    output logic [2*PP_W-1:0] p
);

    // Operands are zero-extended first so the multiply is evaluated at full
    // product width.
    assign p = {{PP_W{1'b0}}, a} * {{PP_W{1'b0}}, b};

endmodule : armleocpu_mul16

// File: rtl/armleocpu_mul32.sv
// Single-cycle-latency, fully pipelined multiplier for the MUL/MULH path.
// The product of the factors sampled on a valid edge appears on result one
// clock later with ready pulsed for that cycle; no backpressure.
// Optional build macro: ARMLEOCPU_MULTIPLIER_SIGNED_EN adds per-factor
// signedness flags (MULH / MULHSU support). Default build is unsigned only.
// XLEN must be a multiple of 16.
module armleocpu_mul32
    import armleocpu_mul_pkg::*;
#(
    parameter int XLEN = MUL_XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [XLEN-1:0]   factor0,
    input  logic [XLEN-1:0]   factor1,
`ifdef ARMLEOCPU_MULTIPLIER_SIGNED_EN
    input  logic              factor0_signed,
    input  logic              factor1_signed,
`endif
    output logic              ready,
    output logic [2*XLEN-1:0] result
);

    localparam int RES_W = 2 * XLEN;
    // Number of 16-bit chunks per factor; the grid is NB x NB blocks.
    localparam int NB    = XLEN / PP_W;

    logic [2*PP_W-1:0] pp [NB*NB];
    logic [RES_W-1:0]  product_next;
    logic [RES_W-1:0]  result_next;
    logic [RES_W-1:0]  result_reg;
    logic              ready_reg;

    // Partial products: block (gi, gj) multiplies chunk gi of factor0 by
    // chunk gj of factor1 and carries weight 2^(16*(gi+gj)).
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_row
            for (genvar gj = 0; gj < NB; gj++) begin : g_col
                armleocpu_mul16 u_mul16 (
                    .a (factor0[gi*PP_W +: PP_W]),
                    .b (factor1[gj*PP_W +: PP_W]),
                    .p (pp[gi*NB + gj])
                );
            end
        end
    endgenerate

    // Sum the shifted partial products into the full unsigned product.
    always_comb begin
        product_next = '0;
        for (int ki = 0; ki < NB*NB; ki++) begin
            product_next = product_next
                         + (RES_W'(pp[ki]) << (PP_W * ((ki / NB) + (ki % NB))));
        end
    end

`ifdef ARMLEOCPU_MULTIPLIER_SIGNED_EN
    // Signed correction. With A = a - ka*2^X and B = b - kb*2^X (ka/kb set
    // when the factor is signed and negative), A*B mod 2^(2X) equals
    // a*b - ka*b*2^X - kb*a*2^X; the ka*kb*2^(2X) term falls off the top.
    // This is the low 2*XLEN bits of the (XLEN+1)-bit sign-extended product.
    logic [RES_W-1:0] corr0;
    logic [RES_W-1:0] corr1;

    always_comb begin
        corr0 = '0;
        corr1 = '0;
        if (factor0_signed && factor0[XLEN-1])
            corr0 = {factor1, {XLEN{1'b0}}};
        if (factor1_signed && factor1[XLEN-1])
            corr1 = {factor0, {XLEN{1'b0}}};
        result_next = product_next - corr0 - corr1;
    end
`else
    // Unsigned build: the product goes straight to the result register.
    always_comb begin
        result_next = product_next;
    end
`endif

    // Result and ready registers; ready is a one-cycle strobe per accept and
    // result holds across idle cycles. Reset clears both asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            ready_reg <= valid;
            if (valid)
                result_reg <= result_next;
        end
    end

    assign ready  = ready_reg;
    assign result = result_reg;

endmodule : armleocpu_mul32

// File: tb/tb_armleocpu_mul32.sv
// Self-checking bench for armleocpu_mul32 (XLEN=32). A behavioural model
// computes each expected product with plain wide arithmetic; directed
// scenarios are followed by a randomized stream.
module tb_armleocpu_mul32;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [31:0] factor0;
    logic [31:0] factor1;
`ifdef ARMLEOCPU_MULTIPLIER_SIGNED_EN
    logic        factor0_signed;
    logic        factor1_signed;
`endif
    logic        ready;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    armleocpu_mul32 #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid          (valid),
        .factor0        (factor0),
        .factor1        (factor1),
`ifdef ARMLEOCPU_MULTIPLIER_SIGNED_EN
        .factor0_signed (factor0_signed),
        .factor1_signed (factor1_signed),
`endif
        .ready          (ready),
        .result         (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: mathematical product of the two factors, each read as
    // signed when its flag is set, reduced modulo 2^64.
    function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                              input logic sa, input logic sb);
        logic signed [65:0] va;
        logic signed [65:0] vb;
        logic signed [65:0] p;
        va = sa ? 66'(signed'(a)) : 66'(a);
        vb = sb ? 66'(signed'(b)) : 66'(b);
        p  = va * vb;
        return p[63:0];
    endfunction

    // Apply inputs away from the active edge.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic sa, input logic sb);
        @(negedge clk);
        valid   = v;
        factor0 = a;
        factor1 = b;
`ifdef ARMLEOCPU_MULTIPLIER_SIGNED_EN
        factor0_signed = sa;
        factor1_signed = sb;
`else
        if (sa || sb) $display("note: signed flags ignored in unsigned build");
`endif
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'd1234, 32'd5678, 1'b0, 1'b0);
        after_edge();
        after_edge();
        checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b result=%h, required ready=0 result=0", ready, result);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            after_edge();
            checks++;
            if (ready !== 1'b0 || result !== 64'd0) begin
                errors++;
                $display("FAIL reset_release_idle[%0d]: ready=%b result=%h, required ready=0 result=0", i, ready, result);
            end
        end
        $display("reset: checked hold and release");
    endtask

    task automatic test_single(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic sa, input logic sb, input logic [63:0] required);
        drive(1'b1, a, b, sa, sb);
        after_edge();
        checks++;
        if (ready !== 1'b1 || result !== required) begin
            errors++;
            $display("FAIL %s: ready=%b result=%h, required ready=1 result=%h", name, ready, result, required);
        end
        drive(1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0);
        after_edge();
        $display("%s: %h * %h -> %h", name, a, b, result);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'd64, 32'd53, 1'b0, 1'b0);
        after_edge();
        checks++;
        if (ready !== 1'b1 || result !== 64'd3392) begin
            errors++;
            $display("FAIL b2b_first: ready=%b result=%h, required ready=1 result=%h", ready, result, 64'd3392);
        end
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        after_edge();
        checks++;
        if (ready !== 1'b1 || result !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL b2b_second: ready=%b result=%h, required ready=1 result=%h", ready, result, 64'hFFFF_FFFE_0000_0001);
        end
        $display("back_to_back: two consecutive accepts checked");
    endtask

    task automatic test_idle_hold();
        // Previous op left max*max in result; factors now wiggle with valid=0.
        drive(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
        after_edge();
        checks++;
        if (ready !== 1'b0 || result !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL idle_hold: ready=%b result=%h, required ready=0 result=%h", ready, result, 64'hFFFF_FFFE_0000_0001);
        end
        drive(1'b0, 32'h0BAD_0BAD, 32'h7777_7777, 1'b0, 1'b0);
        after_edge();
        checks++;
        if (ready !== 1'b0 || result !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL idle_hold2: ready=%b result=%h, required ready=0 result=%h", ready, result, 64'hFFFF_FFFE_0000_0001);
        end
        $display("idle_hold: result held over idle cycles");
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'd1000, 32'd3, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (ready !== 1'b1 || result !== 64'd3000) begin
            errors++;
            $display("FAIL async_pre: ready=%b result=%h, required ready=1 result=%h", ready, result, 64'd3000);
        end
        rst = 1'b1;   // mid-cycle, no clock edge
        #1;
        checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL async_reset: ready=%b result=%h, required ready=0 result=0", ready, result);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;   // released mid-cycle with valid still high
        factor0 = 32'd7;
        factor1 = 32'd9;
        after_edge();
        checks++;
        if (ready !== 1'b1 || result !== 64'd63) begin
            errors++;
            $display("FAIL first_accept_after_reset: ready=%b result=%h, required ready=1 result=%h", ready, result, 64'd63);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        after_edge();
        $display("async_reset: immediate clear and first accept checked");
    endtask

    task automatic test_random(input int n);
        logic [63:0] exp_result;
        logic        exp_ready;
        logic        v, sa, sb;
        logic [31:0] a, b;
        int          local_err;
        exp_result = result;   // state after prior directed tests
        exp_result = 64'd0;
        // Establish a known starting value first.
        drive(1'b1, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        after_edge();
        checks++;
        if (ready !== 1'b1 || result !== 64'd0) begin
            errors++;
            $display("FAIL zero_times_max: ready=%b result=%h, required ready=1 result=0", ready, result);
        end
        local_err = 0;
        for (int i = 0; i < n; i++) begin
            v  = ($urandom_range(3) != 0);
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(7) == 0) a = 32'hFFFF_FFFF;
            if ($urandom_range(7) == 0) b = 32'd0;
`ifdef ARMLEOCPU_MULTIPLIER_SIGNED_EN
            sa = 1'($urandom_range(1));
            sb = 1'($urandom_range(1));
`else
            sa = 1'b0;
            sb = 1'b0;
`endif
            drive(v, a, b, sa, sb);
            exp_ready = v;
            if (v) exp_result = model_mul(a, b, sa, sb);
            after_edge();
            checks++;
            if (ready !== exp_ready || result !== exp_result) begin
                errors++;
                local_err++;
                $display("FAIL random[%0d]: v=%b a=%h b=%h sa=%b sb=%b ready=%b result=%h, required ready=%b result=%h",
                         i, v, a, b, sa, sb, ready, result, exp_ready, exp_result);
            end
        end
        $display("random: %0d cycles, %0d discrepancies", n, local_err);
    endtask

    initial begin
        rst     = 1'b1;
        valid   = 1'b0;
        factor0 = '0;
        factor1 = '0;
`ifdef ARMLEOCPU_MULTIPLIER_SIGNED_EN
        factor0_signed = 1'b0;
        factor1_signed = 1'b0;
`endif
        test_reset();
        test_single("basic", 32'd64, 32'd53, 1'b0, 1'b0, 64'd3392);
        test_single("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
        test_single("zero", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 64'd0);
        test_single("chunk_carry", 32'h0001_FFFF, 32'hFFFF_0001, 1'b0, 1'b0, 64'h0001_FFFD_0002_FFFF);
`ifdef ARMLEOCPU_MULTIPLIER_SIGNED_EN
        test_single("signed_neg1_x2", 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
        test_single("signed_both_neg", 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 1'b1, 64'd6);
        test_single("signed_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
`endif
        test_back_to_back();
        test_idle_hold();
        test_async_reset();
        test_random(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_armleocpu_mul32
